// File: rtl/din_debounce.sv
// Input conditioner: synchronises raw_in into clk, filters it to a stable din level, and emits rise/fall strobes.
// Latency: din follows raw_in after SYNC_STAGES+STABLE_CYCLES edges; shorter pulses are rejected.
// No backpressure; optional reject counter is enabled with GLITCH_CNT_EN.
module din_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       din,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   din_q, din_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            din_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Strobes are registered alongside din so they coincide with the first cycle of the new level.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        din_d   = din_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != din_q) begin
                    if (STABLE_CYCLES == 1) begin
                        din_d  = ~din_q;
                        rise_d = ~din_q;
                        fall_d = din_q;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (s == din_q) begin
                    state_d = ST_STABLE;
                    reject  = 1'b1;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = ST_STABLE;
                    din_d   = ~din_q;
                    rise_d  = ~din_q;
                    fall_d  = din_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    assign din  = din_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_PENDING);

`ifdef GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // Saturates so a noisy line cannot wrap the count back to a misleadingly small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= 8'd0;
        end else if (reject && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_reject;
    assign unused_reject = reject;
    assign glitch_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_din_debounce.sv
// Bench for din_debounce: strobe scoreboard plus directed level/busy/glitch checks.
module tb_din_debounce;
`ifdef GLITCH_CNT_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_in;
    logic       din, rise, fall, busy;
    logic [7:0] glitch_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit is_rise;
        int at;
    } ev_t;

    ev_t exp_q[$];

    din_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .din        (din),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe the DUT presents must match the next expected event.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if (!rst && (rise || fall)) begin
            check("rise_fall_exclusive", 32'(rise && fall), 0);
            check("strobe_not_back_to_back", 32'(prev_strobe), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got rise=%0d fall=%0d expected none (cycle %0d)", rise, fall, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("strobe_kind_rise", 32'(rise), 32'(ev.is_rise));
                check("strobe_cycle", cyc, ev.at);
                check("din_at_strobe", 32'(din), 32'(ev.is_rise));
            end
        end
        prev_strobe <= (rise || fall) && !rst;
    end

    initial begin
        logic saw_busy;
        logic din_seen;
        rst    = 1'b1;
        raw_in = 1'b0;
        tick(2);
        check("reset_din", 32'(din), 0);
        check("reset_rise", 32'(rise), 0);
        check("reset_fall", 32'(fall), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_glitch", 32'(glitch_cnt), 0);
        rst = 1'b0;
        tick(3);

        // 1: clean rise
        raw_in = 1'b1;
        exp_q.push_back('{1'b1, cyc + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("t1_busy_e%0d", k), 32'(busy), 32'(k >= 3 && k <= 5));
            check($sformatf("t1_din_e%0d", k), 32'(din), 32'(k >= 6));
            check($sformatf("t1_rise_e%0d", k), 32'(rise), 32'(k == 6));
        end
        check("t1_glitch", 32'(glitch_cnt), 0);

        // 2: clean fall
        raw_in = 1'b0;
        exp_q.push_back('{1'b0, cyc + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("t2_din_e%0d", k), 32'(din), 32'(k < 6));
            check($sformatf("t2_fall_e%0d", k), 32'(fall), 32'(k == 6));
        end

        // 3: two-cycle glitch
        tick(2);
        raw_in   = 1'b1;
        saw_busy = 1'b0;
        din_seen = 1'b0;
        tick(2);
        raw_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
            din_seen = din_seen | din;
        end
        check("t3_busy_pulsed", 32'(saw_busy), 1);
        check("t3_busy_idle", 32'(busy), 0);
        check("t3_din_low", 32'(din_seen), 0);
        check("t3_glitch", 32'(glitch_cnt), GEN ? 1 : 0);

        // 4: chatter then hold high
        din_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            raw_in = (i % 2 == 0);
            @(negedge clk);
            din_seen = din_seen | din;
        end
        check("t4_din_low_in_chatter", 32'(din_seen), 0);
        raw_in = 1'b1;
        exp_q.push_back('{1'b1, cyc + 6});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t4_din_e%0d", k), 32'(din), 32'(k >= 6));
        end
        check("t4_glitch_nonzero", 32'(glitch_cnt != 8'd0), 32'(GEN));
        tick(4);

        // 5: reset while pending
        raw_in = 1'b0;
        exp_q.push_back('{1'b0, cyc + 6});
        tick(10);
        raw_in = 1'b1;
        tick(3);
        check("t5_busy_before_rst", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_din", 32'(din), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_glitch", 32'(glitch_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{1'b1, cyc + 6});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t5_din_e%0d", k), 32'(din), 32'(k >= 6));
        end
        tick(4);

        // 6: saturation of the reject counter
        raw_in = 1'b0;
        exp_q.push_back('{1'b0, cyc + 6});
        tick(10);
        din_seen = 1'b0;
        for (int p = 0; p < 300; p++) begin
            raw_in = 1'b1;
            @(negedge clk);
            din_seen = din_seen | din;
            raw_in = 1'b0;
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                din_seen = din_seen | din;
            end
            if (p == 259) check("t6_glitch_at_260", 32'(glitch_cnt), GEN ? 255 : 0);
        end
        check("t6_glitch_sat", 32'(glitch_cnt), GEN ? 255 : 0);
        check("t6_din_low", 32'(din_seen), 0);

        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
